wpn_attack_ctrl: RTL
====================

Name: wpn_attack_ctrl

Overview:
Sequencer for the melee weapon datapath. Turns raw mouse clicks into a timed attack: windup, swing, recover, cooldown. It latches facing direction at attack start and drives the animation offset, draw-enable and hit window consumed by the weapon draw and animation path. It sits between the mouse controller and the weapon draw block inside the weapon subsystem, and is clocked by the pixel clock and paced by frame_tick.

Parameters:
WINDUP_FRAMES, 2, frames spent in WINDUP (≥1)
SWING_FRAMES, 4, frames in SWING; RECOVER also lasts this many frames (≥1)
COOLDOWN_FRAMES, 5, frames in COOLDOWN before the next attack (≥1)
SWING_STEP, 3, pixels added to or removed from the offset magnitude per frame_tick in SWING/RECOVER
Constraint: SWING_FRAMES*SWING_STEP ≤ 2047.

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous reset, active-high
enable  in  1  attack allowed (player alive, game running); low aborts the attack
mouse_clicked  in  1  left button level from mouse controller
frame_tick  in  1  one-cycle pulse per video frame
pos_x  in  12  player x position
xpos_MouseCtl  in  12  mouse x position
anim_active  out  1  weapon drawn (state ≠ IDLE and ≠ COOLDOWN)
anim_x_offset  out  12  signed horizontal offset, two's complement
facing_left  out  1  direction latched at attack start
hit_window  out  1  high for the whole of SWING (damage enable)
attack_start  out  1  one-cycle pulse on entry to WINDUP
busy  out  1  state ≠ IDLE

Behaviour:
- click_rise = mouse_clicked & ~click_d. click_d is a register, reset to 0.
- Reset: state=IDLE, frame_cnt=0, mag=0, pending=0, facing_left=0. All outputs 0.
- Each timed state counts frame_tick. On a tick with frame_cnt==N-1, advance to the next state and clear frame_cnt. Otherwise, on a tick, increment frame_cnt. With no tick, hold.
- IDLE: if enable & click_rise, go to WINDUP on the next clk edge, latch facing_left = (xpos_MouseCtl < pos_x) (unsigned), and set frame_cnt=0.
- attack_start is registered and high during the first cycle in WINDUP.
- WINDUP (N=WINDUP_FRAMES): mag=0. Clicks are ignored. Exits to SWING.
- SWING (N=SWING_FRAMES): mag += SWING_STEP on every tick, including the exit tick, so mag peaks at SWING_FRAMES*SWING_STEP on entry to RECOVER. hit_window=1. Clicks are ignored. Exits to RECOVER.
- RECOVER (N=SWING_FRAMES): mag -= SWING_STEP on every tick; mag is exactly 0 on exit. A click_rise sets pending. Exits to COOLDOWN.
- COOLDOWN (N=COOLDOWN_FRAMES): mag=0, anim_active=0. A click_rise sets pending. On exit:
  - if pending & enable: go to WINDUP, re-latch facing_left from the current positions, clear pending, pulse attack_start;
  - otherwise go to IDLE and clear pending.
- Only one click is buffered; extra clicks are dropped.
- anim_x_offset = facing_left ? -mag : mag, registered, same cycle as mag.
- enable low in any state: next clk goes to IDLE, mag=0, frame_cnt=0, pending=0, and outputs clear. This takes priority over frame_tick and click_rise in the same cycle.
- frame_tick and click_rise in the same cycle are handled independently, e.g. in COOLDOWN a click on the exit tick sets pending and is honoured in that transition.
- Idle-to-idle latency: (WINDUP + 2*SWING + COOLDOWN) frames plus at most 1 clk.
- A sync reset mid-attack behaves identically to power-on reset.

Decomposition:
- Package wpn_pkg holds:
  - state enum wpn_atk_state_t {IDLE, WINDUP, SWING, RECOVER, COOLDOWN};
  - default frame-count and step constants;
  - OFFSET_W = 12.
- Sub-module wpn_frame_timer: counts frame_tick up to a runtime limit N; outputs done (on the tick where cnt==N-1) and auto-clears; inputs are clear and limit.

Test Plan:
1. Defaults, enable=1, pos_x=400, xpos=500, single click → attack_start pulses once and facing_left=0. anim_x_offset steps 3,6,9,12 on SWING ticks (hit_window high for 4 frames), then 9,6,3,0 in RECOVER. IDLE is reached after 15 ticks.
2. Same as 1 with xpos=100 → facing_left=1; offsets -3…-12…0 (0xFFD…0xFF4).
3. Click during SWING, then another during COOLDOWN → first is ignored, second is buffered. WINDUP re-enters directly from COOLDOWN with a second attack_start and no IDLE cycle.
4. Three clicks during RECOVER → exactly one follow-up attack, then IDLE.
5. Deassert enable mid-SWING when mag=6 → next clk: state IDLE, mag=0, hit_window=0, busy=0. A click with enable=0 starts no attack.
6. Assert rst during RECOVER with a click pending → all outputs 0. A held-high mouse_clicked after reset does not trigger until it is released and pressed again.

Source files
------------

// File: rtl/wpn_pkg.sv
// Shared types and constants for the melee weapon attack sequencer.
package wpn_pkg;

  // Width of the signed horizontal animation offset.
  localparam int OFFSET_W = 12;

  // Width of the per-state frame counter; covers any sensible frame count.
  localparam int FRAME_CNT_W = 8;

  // Default phase lengths (in frames) and per-frame swing step (in pixels).
  localparam int WINDUP_FRAMES_DEF   = 2;
  localparam int SWING_FRAMES_DEF    = 4;
  localparam int COOLDOWN_FRAMES_DEF = 5;
  localparam int SWING_STEP_DEF      = 3;

  // Attack phases.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WINDUP   = 3'd1,
    SWING    = 3'd2,
    RECOVER  = 3'd3,
    COOLDOWN = 3'd4
  } wpn_atk_state_t;

endpackage

// File: rtl/wpn_frame_timer.sv
// Counts frame ticks up to a runtime limit; flags the tick that completes
// the count and wraps back to zero on that same tick.
module wpn_frame_timer
  import wpn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   tick,
  input  logic [FRAME_CNT_W-1:0] limit,
  output logic                   done
);

  logic [FRAME_CNT_W-1:0] cnt_r;

  assign done = tick & ~clear & (cnt_r == (limit - FRAME_CNT_W'(1)));

  // Frame counter: clear wins, then wrap on done, else count ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (done) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= cnt_r + FRAME_CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/wpn_attack_ctrl.sv
// Melee attack sequencer: click -> windup -> swing -> recover -> cooldown,
// paced by frame_tick. Drives the animation offset, draw enable and hit window.
module wpn_attack_ctrl
  import wpn_pkg::*;
#(
  parameter int WINDUP_FRAMES   = WINDUP_FRAMES_DEF,
  parameter int SWING_FRAMES    = SWING_FRAMES_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int SWING_STEP      = SWING_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mouse_clicked,
  input  logic                frame_tick,
  input  logic [11:0]         pos_x,
  input  logic [11:0]         xpos_MouseCtl,
  output logic                anim_active,
  output logic [OFFSET_W-1:0] anim_x_offset,
  output logic                facing_left,
  output logic                hit_window,
  output logic                attack_start,
  output logic                busy
);

  localparam logic [OFFSET_W-1:0] STEP_C = OFFSET_W'(SWING_STEP);

  wpn_atk_state_t         state_r;
  wpn_atk_state_t         state_nxt_s;
  logic [OFFSET_W-1:0]    mag_r;
  logic [OFFSET_W-1:0]    mag_nxt_s;
  logic                   pending_r;
  logic                   pending_nxt_s;
  logic                   facing_nxt_s;
  logic                   click_d_r;
  logic                   click_arm_r;
  logic                   click_rise_s;
  logic                   dir_left_s;
  logic                   tmr_clear_s;
  logic                   tmr_tick_s;
  logic                   tmr_done_s;
  logic [FRAME_CNT_W-1:0] tmr_limit_s;

  // A press held across reset must be released before it can count again,
  // so the edge detector is only armed once the button has been seen low.
  assign click_rise_s = mouse_clicked & ~click_d_r & click_arm_r;
  assign dir_left_s   = (xpos_MouseCtl < pos_x);
  assign tmr_clear_s  = ~enable | (state_r == IDLE);
  assign tmr_tick_s   = frame_tick & (state_r != IDLE);

  wpn_frame_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear_s),
    .tick  (tmr_tick_s),
    .limit (tmr_limit_s),
    .done  (tmr_done_s)
  );

  // Frame budget of the current phase.
  always_comb begin
    tmr_limit_s = FRAME_CNT_W'(1);
    case (state_r)
      WINDUP:   tmr_limit_s = FRAME_CNT_W'(WINDUP_FRAMES);
      SWING:    tmr_limit_s = FRAME_CNT_W'(SWING_FRAMES);
      RECOVER:  tmr_limit_s = FRAME_CNT_W'(SWING_FRAMES);
      COOLDOWN: tmr_limit_s = FRAME_CNT_W'(COOLDOWN_FRAMES);
      default:  tmr_limit_s = FRAME_CNT_W'(1);
    endcase
  end

  // Next phase, offset magnitude, click buffer and latched direction.
  always_comb begin
    state_nxt_s   = state_r;
    mag_nxt_s     = mag_r;
    pending_nxt_s = pending_r;
    facing_nxt_s  = facing_left;
    if (!enable) begin
      state_nxt_s   = IDLE;
      mag_nxt_s     = '0;
      pending_nxt_s = 1'b0;
      facing_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mag_nxt_s     = '0;
          pending_nxt_s = 1'b0;
          if (click_rise_s) begin
            state_nxt_s  = WINDUP;
            facing_nxt_s = dir_left_s;
          end else begin
            state_nxt_s  = IDLE;
          end
        end
        WINDUP: begin
          mag_nxt_s = '0;
          if (tmr_done_s) begin
            state_nxt_s = SWING;
          end else begin
            state_nxt_s = WINDUP;
          end
        end
        SWING: begin
          if (frame_tick) begin
            mag_nxt_s = mag_r + STEP_C;
          end else begin
            mag_nxt_s = mag_r;
          end
          if (tmr_done_s) begin
            state_nxt_s = RECOVER;
          end else begin
            state_nxt_s = SWING;
          end
        end
        RECOVER: begin
          if (frame_tick) begin
            mag_nxt_s = mag_r - STEP_C;
          end else begin
            mag_nxt_s = mag_r;
          end
          if (click_rise_s) begin
            pending_nxt_s = 1'b1;
          end else begin
            pending_nxt_s = pending_r;
          end
          if (tmr_done_s) begin
            state_nxt_s = COOLDOWN;
          end else begin
            state_nxt_s = RECOVER;
          end
        end
        COOLDOWN: begin
          mag_nxt_s = '0;
          if (tmr_done_s) begin
            pending_nxt_s = 1'b0;
            // A click on the exit tick itself still chains the next attack.
            if (pending_r | click_rise_s) begin
              state_nxt_s  = WINDUP;
              facing_nxt_s = dir_left_s;
            end else begin
              state_nxt_s  = IDLE;
            end
          end else if (click_rise_s) begin
            pending_nxt_s = 1'b1;
          end else begin
            pending_nxt_s = pending_r;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          mag_nxt_s     = '0;
          pending_nxt_s = 1'b0;
          facing_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and outputs, all derived from the next-phase values so
  // every output lines up with the phase it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      mag_r         <= '0;
      pending_r     <= 1'b0;
      click_d_r     <= 1'b0;
      click_arm_r   <= 1'b0;
      facing_left   <= 1'b0;
      anim_active   <= 1'b0;
      anim_x_offset <= '0;
      hit_window    <= 1'b0;
      attack_start  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      mag_r         <= mag_nxt_s;
      pending_r     <= pending_nxt_s;
      click_d_r     <= mouse_clicked;
      click_arm_r   <= click_arm_r | ~mouse_clicked;
      facing_left   <= facing_nxt_s;
      anim_active   <= (state_nxt_s == WINDUP) | (state_nxt_s == SWING) |
                       (state_nxt_s == RECOVER);
      anim_x_offset <= facing_nxt_s ? (OFFSET_W'(0) - mag_nxt_s) : mag_nxt_s;
      hit_window    <= (state_nxt_s == SWING);
      attack_start  <= (state_nxt_s == WINDUP) & (state_r != WINDUP);
      busy          <= (state_nxt_s != IDLE);
    end
  end

endmodule
